// File: rtl/ltc2387_pkg.sv
// Shared types and constants for the LTC2387 two-lane serial receiver.
package ltc2387_pkg;

  localparam int ADC_WIDTH_DEF = 18;
  localparam int LANES         = 2;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    WAIT,
    READ,
    FLUSH,
    DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ltc2387_sync.sv
// Two-flop synchronizer; with EDGE_EN set it also flags any change of the
// synchronized level (rising or falling) for one clk cycle.
module ltc2387_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic edge_det
);

  logic [1:0] sync_ff;

  // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_ff <= '0;
    else          sync_ff <= {sync_ff[0], d};
  end

  assign q = sync_ff[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic q_d;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_d <= 1'b0;
        else          q_d <= sync_ff[1];
      end
      assign edge_det = sync_ff[1] ^ q_d;
    end else begin : g_no_edge
      assign edge_det = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ltc2387_rx.sv
// LTC2387 receiver: drives cnv/adc_clk, captures DDR two-lane data on echoed dco
// edges and presents samples with a valid/ready handshake. Optional LTC2387_RX_STATS_EN.
module ltc2387_rx
  import ltc2387_pkg::*;
#(
  parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
  parameter int CNV_HIGH     = 4,
  parameter int T_CONV       = 30,
  parameter int CLK_HALF     = 2,
  parameter int CNV_PERIOD   = 64,
  parameter int EDGE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic                 cnv,
  output logic                 adc_clk,
  input  logic                 dco,
  input  logic                 da,
  input  logic                 db,
  output logic [ADC_WIDTH-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 frame_err
`ifdef LTC2387_RX_STATS_EN
  ,
  output logic [15:0]          sample_cnt,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int HALF    = ADC_WIDTH / LANES;
  localparam int TOGGLES = HALF + 1;
  localparam int CYC_MAX = max2(max2(CNV_HIGH, T_CONV), max2(CLK_HALF, EDGE_TIMEOUT));
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int PER_W   = $clog2(CNV_PERIOD + 1);
  localparam int TOG_W   = $clog2(TOGGLES + 1);
  localparam int EDG_W   = $clog2(HALF + 1);

  state_t                 state, state_next;
  logic [CYC_W-1:0]       cyc_cnt;
  logic [PER_W-1:0]       period_cnt;
  logic [TOG_W-1:0]       tog_cnt;
  logic [EDG_W-1:0]       edge_cnt;
  logic [ADC_WIDTH-1:0]   shift_reg;
  logic                   started;
  logic                   dco_edge, da_s, db_s;
  logic                   unused_dco_level, unused_da_edge, unused_db_edge;
  logic                   capture, frame_full, half_done, last_toggle, timeout, load;

  ltc2387_sync #(.EDGE_EN(1'b1)) u_dco_sync (
    .clk(clk), .reset_n(reset_n), .d(dco), .q(unused_dco_level), .edge_det(dco_edge)
  );
  ltc2387_sync u_da_sync (
    .clk(clk), .reset_n(reset_n), .d(da), .q(da_s), .edge_det(unused_da_edge)
  );
  ltc2387_sync u_db_sync (
    .clk(clk), .reset_n(reset_n), .d(db), .q(db_s), .edge_det(unused_db_edge)
  );

  // Data lanes share the dco synchronizer depth, so da_s/db_s are aligned with dco_edge.
  assign capture     = dco_edge && (state == READ || state == FLUSH) && (edge_cnt < EDG_W'(HALF));
  assign frame_full  = (edge_cnt == EDG_W'(HALF)) || (capture && edge_cnt == EDG_W'(HALF - 1));
  assign half_done   = (cyc_cnt == CYC_W'(CLK_HALF - 1));
  assign last_toggle = (state == READ) && half_done && (tog_cnt == TOG_W'(TOGGLES - 1));
  assign load        = (state == DONE) && (!sample_valid || sample_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: defaults first so every path assigns state_next and timeout (no latch).
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      IDLE:  if (enable && (!started || period_cnt >= PER_W'(CNV_PERIOD - 1))) state_next = CNV;
      CNV:   if (cyc_cnt == CYC_W'(CNV_HIGH - 1)) state_next = WAIT;
      WAIT:  if (cyc_cnt == CYC_W'(T_CONV - 1)) state_next = READ;
      READ:  if (last_toggle) state_next = frame_full ? DONE : FLUSH;
      FLUSH: begin
        if (frame_full) begin
          state_next = DONE;
        end else if (cyc_cnt == CYC_W'(EDGE_TIMEOUT - 1)) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt    <= '0;
      period_cnt <= '0;
      started    <= 1'b0;
      cnv        <= 1'b0;
    end else begin
      cnv <= (state_next == CNV);
      if (state_next != state || (state == READ && half_done))
        cyc_cnt <= '0;
      else if (state inside {CNV, WAIT, READ, FLUSH})
        cyc_cnt <= cyc_cnt + 1'b1;
      if (state_next == CNV && state != CNV) begin
        period_cnt <= '0;
        started    <= 1'b1;
      end else if (period_cnt != PER_W'(CNV_PERIOD - 1)) begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

  // The initial rise counts as the first toggle; the last toggle always leaves adc_clk low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_clk <= 1'b0;
      tog_cnt <= '0;
    end else if (state == WAIT && state_next == READ) begin
      adc_clk <= 1'b1;
      tog_cnt <= TOG_W'(1);
    end else if (state == READ && half_done) begin
      adc_clk <= last_toggle ? 1'b0 : ~adc_clk;
      tog_cnt <= tog_cnt + 1'b1;
    end
  end

  // NOTE: the shift register is ordinary flops, not a RAM, so it takes the async reset too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      edge_cnt  <= '0;
    end else if (state_next == CNV && state != CNV) begin
      shift_reg <= '0;
      edge_cnt  <= '0;
    end else if (capture) begin
      shift_reg <= {shift_reg[ADC_WIDTH-3:0], da_s, db_s};
      edge_cnt  <= edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= timeout;
      overrun   <= (state == DONE) && !load;
      if (load) begin
        sample_data  <= shift_reg;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

`ifdef LTC2387_RX_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (load) sample_cnt <= sample_cnt + 1'b1;
      if (timeout || ((state == DONE) && !load)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ltc2387_rx.sv
// Directed bench for ltc2387_rx: an ADC model echoes adc_clk on dco with a chosen word,
// frames are driven from a vector table plus hand-written reset and spacing sequences.
module tb_ltc2387_rx;

  logic        clk = 1'b0;
  logic        reset_n, enable, dco, da, db, sample_ready;
  logic        cnv, adc_clk, sample_valid, overrun, frame_err;
  logic [17:0] sample_data;
`ifdef LTC2387_RX_STATS_EN
  logic [15:0] sample_cnt, drop_cnt;
`endif

  ltc2387_rx dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cnv(cnv), .adc_clk(adc_clk),
    .dco(dco), .da(da), .db(db), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .frame_err(frame_err)
`ifdef LTC2387_RX_STATS_EN
    , .sample_cnt(sample_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // ADC model: every adc_clk transition is echoed on dco 3 ns later with the next bit pair.
  logic [17:0] model_word = '0;
  int          model_edges = 10;
  int          edge_idx = 0;

  always @(posedge cnv) edge_idx = 0;

  always @(adc_clk) begin
    if (reset_n) begin
      #3;
      if (edge_idx < model_edges) begin
        if (edge_idx < 9) begin
          da = model_word[17 - 2*edge_idx];
          db = model_word[16 - 2*edge_idx];
        end
        dco = ~dco;
      end
      edge_idx++;
    end
  end

  // Monitor, sampled on the falling edge; per-frame counts restart on each cnv rise.
  int   cyc = 0, cnv_rises = 0, last_rise_cyc = 0, last_spacing = 0, cnv_width = 0;
  int   adc_pulses = 0, last_fall_cyc = 0, dco_cnt = 0, dco9_cyc = 0, last_lat = 0;
  int   f_vrises = 0, f_ovr = 0, f_ferr = 0, ferr_delay = 0;
  bit   rise_seen = 1'b0;
  logic cnv_q = 1'b0, adc_q = 1'b0, dco_q = 1'b0, valid_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (cnv && !cnv_q) begin
      if (rise_seen) last_spacing = cyc - last_rise_cyc;
      rise_seen     = 1'b1;
      last_rise_cyc = cyc;
      cnv_width = 0; adc_pulses = 0; dco_cnt = 0; f_vrises = 0; f_ovr = 0; f_ferr = 0;
      cnv_rises++;
    end
    if (cnv) cnv_width++;
    if (adc_clk && !adc_q) adc_pulses++;
    if (!adc_clk && adc_q) last_fall_cyc = cyc;
    if (dco !== dco_q) begin
      dco_cnt++;
      if (dco_cnt == 9) dco9_cyc = cyc;
    end
    if (sample_valid && !valid_q) begin
      f_vrises++;
      last_lat = cyc - dco9_cyc;
    end
    if (overrun) f_ovr++;
    if (frame_err) begin
      f_ferr++;
      ferr_delay = cyc - last_fall_cyc;
    end
    cnv_q = cnv; adc_q = adc_clk; dco_q = dco; valid_q = sample_valid;
  end

  typedef struct {
    logic [17:0] word;
    int          edges;
    logic        ready;
    logic [17:0] exp_data;
    logic        exp_valid;
    int          exp_rises;
    int          exp_ovr;
    int          exp_ferr;
  } vec_t;

  task automatic wait_cnv_rise(input string name);
    int  start;
    bit  seen;
    start = cnv_rises;
    seen  = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (cnv_rises != start) seen = 1'b1;
    end
    check({name, "_cnv_start"}, seen, 1'b1);
  endtask

  // One frame with enable dropped right after cnv, so no second conversion may follow.
  task automatic check_frame(input string name, input vec_t v);
    int rises0;
    model_word   = v.word;
    model_edges  = v.edges;
    sample_ready = v.ready;
    enable       = 1'b1;
    wait_cnv_rise(name);
    enable = 1'b0;
    rises0 = cnv_rises;
    repeat (75) @(negedge clk);
    check({name, "_extra_cnv"},   cnv_rises - rises0, 0);
    check({name, "_cnv_width"},   cnv_width, 4);
    check({name, "_adc_pulses"},  adc_pulses, 5);
    check({name, "_data"},        sample_data, v.exp_data);
    check({name, "_valid"},       sample_valid, v.exp_valid);
    check({name, "_valid_rises"}, f_vrises, v.exp_rises);
    check({name, "_overrun"},     f_ovr, v.exp_ovr);
    check({name, "_frame_err"},   f_ferr, v.exp_ferr);
    if (v.exp_ferr != 0)  check({name, "_ferr_delay"}, ferr_delay, 16);
    if (v.exp_rises != 0) check({name, "_latency"}, last_lat, 4);
  endtask

  vec_t vecs [8];
  vec_t post [4];

  initial begin
    //          word      edges rdy   exp_data  vld  rises ovr ferr
    vecs[0] = '{18'h2AAAA, 10, 1'b1, 18'h2AAAA, 1'b0, 1, 0, 0};
    vecs[1] = '{18'h2AAAA, 10, 1'b0, 18'h2AAAA, 1'b1, 1, 0, 0};
    vecs[2] = '{18'h15555, 10, 1'b0, 18'h2AAAA, 1'b1, 0, 1, 0};
    vecs[3] = '{18'h2AAAA, 10, 1'b0, 18'h2AAAA, 1'b1, 0, 1, 0};
    vecs[4] = '{18'h15555, 10, 1'b0, 18'h2AAAA, 1'b1, 0, 1, 0};
    vecs[5] = '{18'h3C5A6, 10, 1'b1, 18'h3C5A6, 1'b0, 1, 0, 0};
    vecs[6] = '{18'h155AA,  8, 1'b1, 18'h3C5A6, 1'b0, 0, 0, 1};
    vecs[7] = '{18'h20001, 10, 1'b0, 18'h20001, 1'b1, 1, 0, 0};
    post[0] = '{18'h0F0F0, 10, 1'b1, 18'h0F0F0, 1'b0, 1, 0, 0};
    post[1] = '{18'h1111F, 10, 1'b0, 18'h1111F, 1'b1, 1, 0, 0};
    post[2] = '{18'h2BCDE, 10, 1'b0, 18'h1111F, 1'b1, 0, 1, 0};
    post[3] = '{18'h0ABCD, 10, 1'b1, 18'h0ABCD, 1'b0, 1, 0, 0};

    reset_n = 1'b0; enable = 1'b0; sample_ready = 1'b0;
    dco = 1'b0; da = 1'b0; db = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cnv",       cnv, 1'b0);
    check("rst_adc_clk",   adc_clk, 1'b0);
    check("rst_valid",     sample_valid, 1'b0);
    check("rst_overrun",   overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_data",      sample_data, 18'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) check_frame($sformatf("v%0d", i), vecs[i]);

    // Reset while reading: outputs drop at once and the frame is abandoned.
    model_word = 18'h3FFFF; model_edges = 10; sample_ready = 1'b0; enable = 1'b1;
    wait_cnv_rise("rst_frame");
    enable = 1'b0;
    for (int i = 0; i < 100 && !adc_clk; i++) @(negedge clk);
    check("rst_reached_read", adc_clk, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_cnv",     cnv, 1'b0);
    check("midrst_adc_clk", adc_clk, 1'b0);
    check("midrst_valid",   sample_valid, 1'b0);
    check("midrst_data",    sample_data, 18'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    begin
      int rises0;
      rises0 = cnv_rises;
      repeat (80) @(negedge clk);
      check("post_rst_idle_valid", sample_valid, 1'b0);
      check("post_rst_idle_cnv",   cnv_rises - rises0, 0);
    end
    for (int i = 0; i < 4; i++) check_frame($sformatf("p%0d", i), post[i]);
`ifdef LTC2387_RX_STATS_EN
    check("stats_sample_cnt", sample_cnt, 16'd3);
    check("stats_drop_cnt",   drop_cnt, 16'd1);
`endif

    // Back-to-back conversions with enable held: rises exactly CNV_PERIOD apart.
    model_word = 18'h3FFFF; model_edges = 10; sample_ready = 1'b1; enable = 1'b1;
    wait_cnv_rise("bb0");
    wait_cnv_rise("bb1");
    check("bb1_spacing", last_spacing, 64);
    wait_cnv_rise("bb2");
    check("bb2_spacing", last_spacing, 64);
    enable = 1'b0;
    repeat (75) @(negedge clk);
    check("bb_data",  sample_data, 18'h3FFFF);
    check("bb_valid", sample_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ltc2387_rx.md
LTC2387_RX -- requirements
Module: ltc2387_rx

Interface
REQ-001 Parameter ADC_WIDTH, default 18, sample width in bits; SHALL be even.
REQ-002 Parameter CNV_HIGH, default 4, cnv high time in clk cycles.
REQ-003 Parameter T_CONV, default 30, clk cycles from cnv fall to the first adc_clk rise.
REQ-004 Parameter CLK_HALF, default 2, clk cycles per adc_clk half-period.
REQ-005 Parameter CNV_PERIOD, default 64, minimum clk cycles between cnv rises.
REQ-006 Parameter EDGE_TIMEOUT, default 16, clk cycles allowed after the last adc_clk fall for outstanding dco edges.
REQ-007 Ports SHALL be as follows.
- clk  in  1  single system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new conversions.
- cnv  out  1  conversion start to the ADC.
- adc_clk  out  1  gated read clock to the ADC.
- dco  in  1  data clock echoed by the ADC.
- da  in  1  lane A, odd bits.
- db  in  1  lane B, even bits.
- sample_data  out  ADC_WIDTH  assembled sample.
- sample_valid  out  1  sample_data holds an unconsumed sample.
- sample_ready  in  1  consumer accepts.
- overrun  out  1  one-cycle pulse when a completed sample is dropped.
- frame_err  out  1  one-cycle pulse on edge timeout.

Function
REQ-008 dco, da and db SHALL each pass through a 2-flop synchronizer; dco edges SHALL be detected on the synchronized value, both rising and falling.
REQ-009 The FSM SHALL have states IDLE, CNV, WAIT, READ, FLUSH, DONE.
REQ-010 IDLE->CNV when enable=1 and the period counter is >= CNV_PERIOD-1, or on the first conversion after reset.
REQ-011 CNV SHALL drive cnv=1 for exactly CNV_HIGH cycles, then go to WAIT; the period counter SHALL restart on cnv rise.
REQ-012 WAIT SHALL last T_CONV cycles with cnv=0, then go to READ.
REQ-013 READ SHALL toggle adc_clk every CLK_HALF cycles, starting high, for exactly ADC_WIDTH/2+1 toggles (5 pulses at 18 bits), ending low, then go to FLUSH.
REQ-014 Each detected dco edge, in READ or FLUSH, SHALL shift {da,db} into the shift register MSB-first: first edge = bits [17:16], ninth = [1:0].
REQ-015 Edges beyond ADC_WIDTH/2 in a frame SHALL be ignored.
REQ-016 When ADC_WIDTH/2 edges have been captured and the toggles are complete, the FSM SHALL go to DONE.
REQ-017 If EDGE_TIMEOUT cycles in FLUSH pass before that, frame_err SHALL pulse, the frame SHALL be discarded and the FSM SHALL return to IDLE.
REQ-018 DONE (one cycle) SHALL load the output register:
- If sample_valid=0, or sample_ready=1 in the same cycle: load, set sample_valid=1.
- Otherwise: keep the old sample and pulse overrun.
- In all cases, return to IDLE.
REQ-019 Handshake: sample_valid SHALL clear the cycle after sample_valid&&sample_ready unless reloaded that cycle; sample_data SHALL be stable while sample_valid=1.
REQ-020 enable falling mid-frame SHALL let the current frame complete; no new cnv SHALL follow.
REQ-021 Latency from the last captured edge to sample_valid SHALL be 2 clk cycles.

Reset
REQ-022 reset_n=0 SHALL asynchronously force:
- state=IDLE;
- cnv, adc_clk, sample_valid, overrun and frame_err to 0;
- sample_data to 0;
- all counters, synchronizers and the shift register to 0.
REQ-023 Reset mid-frame SHALL abandon the frame with no output.

Configuration
REQ-024 With LTC2387_RX_STATS_EN defined, the block SHALL add outputs sample_cnt[15:0] (accepted samples) and drop_cnt[15:0] (overrun plus frame_err events), both wrapping at 16'hFFFF->0 and cleared by reset.
REQ-025 Without LTC2387_RX_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-026 Package ltc2387_pkg SHALL hold the FSM state enum, the ADC_WIDTH default and the lane-count constant (2).
REQ-027 Sub-module ltc2387_sync SHALL hold the 2-flop synchronizer with edge detect, instantiated for dco; da and db SHALL use plain synchronizer instances.

Verification
REQ-028 A model returning 18'h2AAAA with ready held 1 SHALL produce sample_data=18'h2AAAA with one valid pulse.
REQ-029 Alternating 18'h2AAAA/18'h15555 with ready=0 after the first sample SHALL hold 18'h2AAAA, pulse overrun once per later frame and leave sample_valid=1.
REQ-030 A model emitting only 8 dco edges SHALL pulse frame_err EDGE_TIMEOUT cycles after the last adc_clk fall, with no valid.
REQ-031 reset_n low during READ SHALL drive cnv=0, adc_clk=0, sample_valid=0 immediately, and the next frame after release SHALL be correct.
REQ-032 Timing checks with defaults:
- cnv high exactly 4 cycles;
- cnv-rise spacing >= 64 cycles;
- exactly 5 adc_clk pulses per frame.
REQ-033 With LTC2387_RX_STATS_EN, 3 accepted samples and 1 overrun SHALL give sample_cnt=3 and drop_cnt=1.
